// File: rtl/cpu_gpr.sv
// General-purpose register file: REG_NUM x DATA_W, two combinational read ports,
// one clocked write port, with write-to-read bypass and asynchronous active-low clear.
module cpu_gpr #(
  parameter int REG_NUM    = 32,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] rd_addr_0,
  output logic [DATA_W-1:0]     rd_data_0,
  input  logic [REG_ADDR_W-1:0] rd_addr_1,
  output logic [DATA_W-1:0]     rd_data_1,
  input  logic                  we_n,
  input  logic [REG_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data
);

  logic [DATA_W-1:0] regs_q [REG_NUM];
  logic [DATA_W-1:0] regs_d [REG_NUM];
  logic [REG_NUM-1:0] wr_sel;

  generate
    for (genvar gi = 0; gi < REG_NUM; gi++) begin : gen_reg
      assign wr_sel[gi] = !we_n && (wr_addr == REG_ADDR_W'(gi));
      assign regs_d[gi] = wr_sel[gi] ? wr_data : regs_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= regs_d[i];
    end
  end

  // Bypass is gated by reset so a held-cleared array never leaks pending write data.
  logic bypass_0, bypass_1;
  assign bypass_0 = reset && !we_n && (wr_addr == rd_addr_0);
  assign bypass_1 = reset && !we_n && (wr_addr == rd_addr_1);

  always_comb begin
    rd_data_0 = regs_q[rd_addr_0];
    rd_data_1 = regs_q[rd_addr_1];
    if (bypass_0) rd_data_0 = wr_data;
    if (bypass_1) rd_data_1 = wr_data;
  end

endmodule

// File: tb/tb_cpu_gpr.sv
// Self-checking bench for cpu_gpr: expected read values are queued when the read
// is driven and popped/compared once the combinational outputs settle.
module tb_cpu_gpr;

  logic        clk;
  logic        reset;
  logic [4:0]  rd_addr_0, rd_addr_1, wr_addr;
  logic [31:0] rd_data_0, rd_data_1, wr_data;
  logic        we_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] e0;
    logic [31:0] e1;
  } exp_t;
  exp_t sb[$];

  logic [31:0] mdl [32];

  cpu_gpr #(.REG_NUM(32), .REG_ADDR_W(5), .DATA_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_0 (rd_addr_0),
    .rd_data_0 (rd_data_0),
    .rd_addr_1 (rd_addr_1),
    .rd_data_1 (rd_data_1),
    .we_n      (we_n),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end else begin
      $display("ok   %s got %h", tag, got);
    end
  endtask

  // Drive both read addresses, queue the expectation, sample 1ns later.
  task automatic rd(input string tag, input logic [4:0] a0, input logic [4:0] a1,
                    input logic [31:0] e0, input logic [31:0] e1);
    exp_t x;
    rd_addr_0 = a0;
    rd_addr_1 = a1;
    x.tag = tag; x.e0 = e0; x.e1 = e1;
    sb.push_back(x);
    #1;
    x = sb.pop_front();
    check_eq({x.tag, "_p0"}, rd_data_0, x.e0);
    check_eq({x.tag, "_p1"}, rd_data_1, x.e1);
  endtask

  initial begin
    reset = 1'b0; we_n = 1'b1; wr_addr = '0; wr_data = '0;
    rd_addr_0 = '0; rd_addr_1 = 5'd1;

    // 1. reset held, then released
    #22;
    rd("in_reset", 5'd0, 5'd1, 32'h0, 32'h0);
    #28;
    @(negedge clk); reset = 1'b1;
    rd("after_reset", 5'd0, 5'd1, 32'h0, 32'h0);

    // 2. blocked write
    @(negedge clk); we_n = 1'b1; wr_addr = 5'd0; wr_data = 32'hAAAA;
    @(posedge clk); @(posedge clk); #1;
    rd("blocked_wr", 5'd0, 5'd0, 32'h0, 32'h0);

    // 3. bypass before the edge, array after
    @(negedge clk); we_n = 1'b0; wr_addr = 5'd1; wr_data = 32'h1234;
    rd("bypass_pre", 5'd1, 5'd3, 32'h1234, 32'h0);
    @(posedge clk); #1;
    rd("bypass_post", 5'd1, 5'd3, 32'h1234, 32'h0);
    @(negedge clk); we_n = 1'b1;
    rd("array_r1", 5'd1, 5'd1, 32'h1234, 32'h1234);

    // 4. second register, concurrent reads
    @(negedge clk); we_n = 1'b0; wr_addr = 5'd2; wr_data = 32'h5678;
    @(posedge clk); #1;
    @(negedge clk); we_n = 1'b1; wr_data = 32'hFFFF_FFFF;
    rd("two_regs", 5'd1, 5'd2, 32'h1234, 32'h5678);

    // dual-port bypass on the same address
    @(negedge clk); we_n = 1'b0; wr_addr = 5'd7; wr_data = 32'hCAFE_0007;
    rd("dual_bypass", 5'd7, 5'd7, 32'hCAFE_0007, 32'hCAFE_0007);
    @(posedge clk); #1;
    @(negedge clk); we_n = 1'b1;
    rd("r7_array", 5'd7, 5'd2, 32'hCAFE_0007, 32'h5678);

    // 5. async reset pulse between edges; bypass suppressed, edge-write lost
    @(negedge clk); #2; reset = 1'b0;
    rd("async_clr", 5'd1, 5'd2, 32'h0, 32'h0);
    we_n = 1'b0; wr_addr = 5'd1; wr_data = 32'hFFFF;
    rd("rst_no_byp", 5'd1, 5'd1, 32'h0, 32'h0);
    @(posedge clk); #1;
    rd("rst_edge", 5'd1, 5'd7, 32'h0, 32'h0);
    @(negedge clk); we_n = 1'b1; reset = 1'b1;
    rd("post_rst", 5'd2, 5'd1, 32'h0, 32'h0);

    // 6. fill all registers, read every pair
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      we_n = 1'b0; wr_addr = 5'(i); wr_data = 32'(i) * 32'h0101_0101;
      mdl[i] = 32'(i) * 32'h0101_0101;
      @(posedge clk); #1;
    end
    @(negedge clk); we_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rd($sformatf("fill_%0d", i), 5'(i), 5'(31 - i), mdl[i], mdl[31 - i]);
    end

    // write attempted while reset held
    @(negedge clk); reset = 1'b0; we_n = 1'b0; wr_addr = 5'd5; wr_data = 32'hDEAD;
    @(posedge clk); #1;
    @(negedge clk); we_n = 1'b1; reset = 1'b1;
    rd("rst_write", 5'd5, 5'd31, 32'h0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
